// File: rtl/cache_wb_buffer.sv
// Single-entry dirty-victim writeback buffer: captures an evicted dirty line and
// drains it to the bus as ascending-address beats while flagging matching lookups.
module cache_wb_buffer #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7,
  parameter int TAGLEN  = 20,
  parameter int LINELEN = 256,
  parameter int BEATLEN = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          EvictReq,
  input  logic [NUMWAYS-1:0]                            VictimWay,
  input  logic [NUMWAYS-1:0]                            ValidWay,
  input  logic [NUMWAYS-1:0]                            DirtyWay,
  input  logic [NUMWAYS*TAGLEN-1:0]                     TagWay,
  input  logic [NUMWAYS*LINELEN-1:0]                    LineWay,
  input  logic [SETLEN-1:0]                             CacheSet,
  output logic                                          EvictStall,
  output logic                                          EvictDone,
  input  logic [TAGLEN-1:0]                             LookupTag,
  input  logic [SETLEN-1:0]                             LookupSet,
  output logic                                          LookupHit,
  output logic                                          WBValid,
  input  logic                                          WBReady,
  output logic [TAGLEN+SETLEN+$clog2(LINELEN/8)-1:0]    WBAdr,
  output logic [BEATLEN-1:0]                            WBData,
  output logic                                          WBLast,
  output logic                                          DbgState
);

  localparam int BEATS     = LINELEN / BEATLEN;
  localparam int OFFSETLEN = $clog2(LINELEN / 8);
  localparam int BEATLOG   = $clog2(BEATS);
  localparam int BEATW     = (BEATLOG < 1) ? 1 : BEATLOG;
  localparam int LOWLEN    = OFFSETLEN - BEATLOG;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} drainStateT;

  drainStateT          state;
  logic [BEATW-1:0]    beat;
  logic                evictDoneReg;
  logic [LINELEN-1:0]  lineReg;
  logic [TAGLEN-1:0]   tagReg;
  logic [SETLEN-1:0]   setReg;

  logic [NUMWAYS-1:0]  victimLow;
  logic [NUMWAYS-1:0]  sel;
  logic [LINELEN-1:0]  selLine;
  logic [TAGLEN-1:0]   selTag;
  logic                lastBeat;
  logic                accept;

  // A multi-hot victim collapses to its lowest bit before the valid/dirty qualification.
  assign victimLow = VictimWay & (~VictimWay + NUMWAYS'(1));
  assign sel       = victimLow & ValidWay & DirtyWay;
  assign accept    = (state == IDLE) && EvictReq && (|sel);
  assign lastBeat  = (beat == BEATW'(BEATS - 1));

  always_comb begin
    selLine = '0;
    selTag  = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (sel[i]) begin
        selLine = LineWay[i*LINELEN +: LINELEN];
        selTag  = TagWay[i*TAGLEN +: TAGLEN];
      end
    end
  end

  // Bus handshake: a beat transfers on any edge where WBValid && WBReady; once
  // WBValid is raised, WBAdr/WBData/WBLast hold until that transfer (or reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      evictDoneReg <= 1'b0;
    end else begin
      evictDoneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (EvictReq) begin
            if (|sel) begin
              beat  <= '0;
              state <= DRAIN;
            end else begin
              evictDoneReg <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (WBReady) begin
            beat <= beat + BEATW'(1);
            if (lastBeat) begin
              state        <= IDLE;
              evictDoneReg <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line payload needs no reset: it is only observed while draining.
  always_ff @(posedge clk) begin
    if (accept) begin
      lineReg <= selLine;
      tagReg  <= selTag;
      setReg  <= CacheSet;
    end
  end

  generate
    if (BEATLOG == 0) begin : gAdrSingle
      assign WBAdr = {tagReg, setReg, {OFFSETLEN{1'b0}}};
    end else begin : gAdrMulti
      assign WBAdr = {tagReg, setReg, beat[BEATLOG-1:0], {LOWLEN{1'b0}}};
    end
  endgenerate

  assign WBData     = lineReg[int'(beat)*BEATLEN +: BEATLEN];
  assign WBValid    = (state == DRAIN);
  assign WBLast     = (state == DRAIN) && lastBeat;
  assign EvictDone  = evictDoneReg;
  assign EvictStall = EvictReq && (state == DRAIN);
  assign LookupHit  = (state == DRAIN) && (LookupTag == tagReg) && (LookupSet == setReg);
  assign DbgState   = state;

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Randomized scoreboard bench for cache_wb_buffer: a transaction-level model expands
// each accepted eviction into expected beats; a negedge monitor compares every cycle.
module tb_cache_wb_buffer;

  localparam int NUMWAYS   = 4;
  localparam int SETLEN    = 7;
  localparam int TAGLEN    = 20;
  localparam int LINELEN   = 256;
  localparam int BEATLEN   = 64;
  localparam int BEATS     = LINELEN / BEATLEN;
  localparam int OFFSETLEN = $clog2(LINELEN / 8);
  localparam int PALEN     = TAGLEN + SETLEN + OFFSETLEN;
  localparam int EW        = PALEN + BEATLEN + 1;

  logic                       clk;
  logic                       reset;
  logic                       EvictReq;
  logic [NUMWAYS-1:0]         VictimWay, ValidWay, DirtyWay;
  logic [NUMWAYS*TAGLEN-1:0]  TagWay;
  logic [NUMWAYS*LINELEN-1:0] LineWay;
  logic [SETLEN-1:0]          CacheSet;
  logic                       EvictStall, EvictDone;
  logic [TAGLEN-1:0]          LookupTag;
  logic [SETLEN-1:0]          LookupSet;
  logic                       LookupHit;
  logic                       WBValid, WBReady, WBLast;
  logic [PALEN-1:0]           WBAdr;
  logic [BEATLEN-1:0]         WBData;
  logic                       DbgState;

  cache_wb_buffer #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN),
    .LINELEN(LINELEN), .BEATLEN(BEATLEN)
  ) dut (
    .clk(clk), .reset(reset), .EvictReq(EvictReq), .VictimWay(VictimWay),
    .ValidWay(ValidWay), .DirtyWay(DirtyWay), .TagWay(TagWay), .LineWay(LineWay),
    .CacheSet(CacheSet), .EvictStall(EvictStall), .EvictDone(EvictDone),
    .LookupTag(LookupTag), .LookupSet(LookupSet), .LookupHit(LookupHit),
    .WBValid(WBValid), .WBReady(WBReady), .WBAdr(WBAdr), .WBData(WBData),
    .WBLast(WBLast), .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                takeCount = 0;
  bit                mBusy = 0;
  bit                mDone = 0;
  logic [TAGLEN-1:0] mTag = '0;
  logic [SETLEN-1:0] mSet = '0;
  bit                rdyRandom = 0;
  int                drainCycles = 0;
  int                lastDrain = 0;
  logic [PALEN-1:0]  firstAdr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted dirty eviction becomes BEATS bus beats at consecutive
  // beat-sized byte offsets from the line base address, lowest data first.
  function automatic void model_take();
    int way = -1;
    logic [TAGLEN-1:0]  tag;
    logic [LINELEN-1:0] line;
    logic [PALEN-1:0]   base;
    for (int i = NUMWAYS - 1; i >= 0; i--) if (VictimWay[i]) way = i;
    if (way < 0) return;
    if (!(ValidWay[way] && DirtyWay[way])) return;
    tag  = TagWay[way*TAGLEN +: TAGLEN];
    line = LineWay[way*LINELEN +: LINELEN];
    base = PALEN'({tag, CacheSet}) << OFFSETLEN;
    for (int b = 0; b < BEATS; b++) begin
      logic [PALEN-1:0]   adr;
      logic [BEATLEN-1:0] dat;
      adr = base + PALEN'(b * (BEATLEN / 8));
      dat = BEATLEN'(line >> (b * BEATLEN));
      exp_q.push_back({adr, dat, (b == BEATS - 1)});
    end
    mTag = tag;
    mSet = CacheSet;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      bit nextDone;
      @(negedge clk);
      check("WBValid", WBValid, mBusy);
      check("DbgState", DbgState, mBusy);
      check("EvictDone", EvictDone, mDone);
      check("EvictStall", EvictStall, EvictReq && mBusy);
      check("LookupHit", LookupHit, mBusy && (LookupTag == mTag) && (LookupSet == mSet));
      if (mBusy && WBValid && exp_q.size() > 0) begin
        check("WBAdr", WBAdr, exp_q[0][EW-1 -: PALEN]);
        check("WBData", WBData, exp_q[0][BEATLEN:1]);
        check("WBLast", WBLast, exp_q[0][0]);
      end
      if (WBValid) begin
        if (drainCycles == 0) firstAdr = WBAdr;
        drainCycles++;
      end
      if (EvictDone) begin
        lastDrain   = drainCycles;
        drainCycles = 0;
      end
      nextDone = 0;
      if (reset) begin
        mBusy = 0;
        exp_q.delete();
        drainCycles = 0;
      end else if (mBusy) begin
        if (WBReady) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            mBusy    = 0;
            nextDone = 1;
          end
        end
      end else if (EvictReq) begin
        takeCount++;
        model_take();
        if (exp_q.size() == 0) nextDone = 1;
        else mBusy = 1;
      end
      mDone = nextDone;
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ways();
    for (int w = 0; w < NUMWAYS; w++) begin
      TagWay[w*TAGLEN +: TAGLEN] = TAGLEN'($urandom());
      for (int k = 0; k < LINELEN / 32; k++)
        LineWay[w*LINELEN + k*32 +: 32] = $urandom();
    end
  endtask

  // Holds the request until the model reports it taken, as a stalled controller would.
  task automatic evict(input logic [NUMWAYS-1:0] victim, input logic [NUMWAYS-1:0] valid,
                       input logic [NUMWAYS-1:0] dirty, input logic [SETLEN-1:0] set);
    int start = takeCount;
    VictimWay = victim;
    ValidWay  = valid;
    DirtyWay  = dirty;
    CacheSet  = set;
    EvictReq  = 1'b1;
    for (int i = 0; i < 200 && takeCount == start; i++) step();
    EvictReq = 1'b0;
    checks++;
    if (takeCount == start) begin
      errors++;
      $display("FAIL evictAccept: request not taken within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!mBusy && !mDone) break;
      step();
    end
    checks++;
    if (mBusy || mDone) begin
      errors++;
      $display("FAIL idleTimeout: drain did not finish within 300 cycles");
    end
  endtask

  // Random bus backpressure and lookups, active only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdyRandom) begin
        WBReady   = ($urandom_range(0, 3) != 0);
        LookupTag = ($urandom_range(0, 1) != 0) ? mTag : TAGLEN'($urandom());
        LookupSet = ($urandom_range(0, 1) != 0) ? mSet : SETLEN'($urandom());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; EvictReq = 1'b0; VictimWay = '0; ValidWay = '0; DirtyWay = '0;
    TagWay = '0; LineWay = '0; CacheSet = '0; LookupTag = '0; LookupSet = '0;
    WBReady = 1'b1;
    fill_ways();
    repeat (3) step();
    reset = 1'b0;
    step();

    // Dirty drain of way 1
    LookupTag = 20'hABCDE; LookupSet = 7'h15;
    TagWay[1*TAGLEN +: TAGLEN] = 20'hABCDE;
    evict(4'b0010, 4'hF, 4'hF, 7'h15);
    wait_idle();
    check("dirtyDrainLen", lastDrain, BEATS);
    check("dirtyFirstAdr", firstAdr, 32'hABCDE2A0);

    // Clean victim: retired without bus activity
    evict(4'b0100, 4'hF, 4'b1011, 7'h15);
    wait_idle();
    check("cleanDrainLen", lastDrain, 0);

    // Backpressure on beat 2 for three cycles
    fill_ways();
    TagWay[1*TAGLEN +: TAGLEN] = 20'hABCDE;
    evict(4'b0010, 4'hF, 4'hF, 7'h15);
    step();
    step();
    WBReady = 1'b0;
    repeat (3) step();
    WBReady = 1'b1;
    wait_idle();
    check("backpressureLen", lastDrain, BEATS + 3);

    // Busy stall with matching and mismatching lookups, then a held request
    fill_ways();
    TagWay[1*TAGLEN +: TAGLEN] = 20'hABCDE;
    TagWay[2*TAGLEN +: TAGLEN] = 20'h13579;
    evict(4'b0010, 4'hF, 4'hF, 7'h15);
    step();
    LookupSet = 7'h16;
    evict(4'b0100, 4'hF, 4'hF, 7'h33);
    wait_idle();
    check("heldReqFirstAdr", firstAdr, PALEN'({20'h13579, 7'h33}) << OFFSETLEN);

    // Reset after beat 1, then a fresh drain starts at beat 0
    fill_ways();
    evict(4'b0001, 4'hF, 4'hF, 7'h05);
    step();
    WBReady = 1'b0;
    reset   = 1'b1;
    step();
    reset   = 1'b0;
    WBReady = 1'b1;
    step();
    TagWay[3*TAGLEN +: TAGLEN] = 20'h2468A;
    evict(4'b1000, 4'hF, 4'hF, 7'h7F);
    wait_idle();
    check("postResetFirstAdr", firstAdr, PALEN'({20'h2468A, 7'h7F}) << OFFSETLEN);
    check("postResetLen", lastDrain, BEATS);

    // Multi-hot victim selects the lowest way
    fill_ways();
    TagWay[1*TAGLEN +: TAGLEN] = 20'h11111;
    TagWay[2*TAGLEN +: TAGLEN] = 20'h22222;
    evict(4'b0110, 4'hF, 4'hF, 7'h2C);
    wait_idle();
    check("multiHotFirstAdr", firstAdr, PALEN'({20'h11111, 7'h2C}) << OFFSETLEN);

    // Random phase: back-to-back requests, stalls, backpressure, lookups
    rdyRandom = 1;
    for (int n = 0; n < 60; n++) begin
      fill_ways();
      evict(NUMWAYS'($urandom_range(0, 15)), NUMWAYS'($urandom_range(0, 15)),
            NUMWAYS'($urandom_range(0, 15)), SETLEN'($urandom()));
      repeat ($urandom_range(0, 3)) step();
    end
    rdyRandom = 0;
    WBReady   = 1'b1;
    step();
    wait_idle();
    check("queueEmpty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
